fdiv: RTL and testbench

- Iterative single-precision floating-point divider, y = x1 / x2. It is the inverse operation of the FPU multiplier.
- Radix-2 restoring mantissa division, producing UNROLL quotient bits per cycle.
- Valid/ready handshake on both sides. One operation in flight at a time.
- Same number conventions as the FPU multiplier: no denormals, truncation (no rounding), exponent 0 means zero, exponent 255 means inf.

---
 rtl/fdiv.sv | 180 ++++++++++++++++++
 tb/tb_fdiv.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv.sv
// Iterative single-precision divider y = x1 / x2: truncating, no denormals, UNROLL restoring quotient bits per cycle.
// Optional macro FDIV_EARLY_SPECIAL_EN lets special operands bypass the DIV phase.
module fdiv #(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        dbz
);
    localparam int N = 25 / UNROLL;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [25:0] rem_q, rem_d;
    logic [24:0] quo_q, quo_d;
    logic [23:0] m2_q, m2_d;
    logic [7:0]  e1_q, e1_d;
    logic [7:0]  e2_q, e2_d;
    logic        sign_q, sign_d;
    logic [31:0] y_q, y_d;
    logic        ovf_q, ovf_d;
    logic        dbz_q, dbz_d;

    logic              in_special;
    logic [25:0]       rem_chain [0:UNROLL];
    logic [UNROLL-1:0] qbit;

    logic signed [9:0] ye0;
    logic [22:0]       ym;
    logic [31:0]       res_y;
    logic              res_ovf;
    logic              res_dbz;

`ifdef FDIV_EARLY_SPECIAL_EN
    assign in_special = (x1[30:23] == 8'h00) || (x1[30:23] == 8'hFF) ||
                        (x2[30:23] == 8'h00) || (x2[30:23] == 8'hFF);
`else
    assign in_special = 1'b0;
`endif

    // Restoring division chain: each stage tries a subtract, keeps it if non-negative, then brings down a zero.
    assign rem_chain[0] = rem_q;
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
        logic [25:0] diff;
        logic        take;
        assign diff = rem_chain[gi] - {2'b00, m2_q};
        assign take = (rem_chain[gi] >= {2'b00, m2_q});
        assign qbit[UNROLL-1-gi] = take;
        assign rem_chain[gi+1] = (take ? diff : rem_chain[gi]) << 1;
    end

    // Result formation from the completed quotient; special operands dominate.
    always_comb begin
        ye0 = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd127
              - (quo_q[24] ? 10'sd0 : 10'sd1);
        ym  = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

        res_y   = {sign_q, 31'b0};
        res_ovf = 1'b0;
        res_dbz = 1'b0;

        if (e2_q == 8'h00) begin
            res_y   = {sign_q, 8'hFF, 23'b0};
            res_dbz = 1'b1;
        end else if (e1_q == 8'hFF) begin
            res_y = {sign_q, 8'hFF, 23'b0};
        end else if (e1_q == 8'h00) begin
            res_y = {sign_q, 31'b0};
        end else if (e2_q == 8'hFF) begin
            res_y = {sign_q, 31'b0};
        end else if (ye0 >= 10'sd255) begin
            res_y   = {sign_q, 8'hFF, 23'b0};
            res_ovf = 1'b1;
        end else if (ye0 <= 10'sd0) begin
            res_y = {sign_q, 31'b0};
        end else begin
            res_y = {sign_q, ye0[7:0], ym};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        m2_d    = m2_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        sign_d  = sign_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_special ? ST_NORM : ST_DIV;
                    cnt_d   = '0;
                    rem_d   = {2'b00, 1'b1, x1[22:0]};
                    quo_d   = '0;
                    m2_d    = {1'b1, x2[22:0]};
                    e1_d    = x1[30:23];
                    e2_d    = x2[30:23];
                    sign_d  = x1[31] ^ x2[31];
                    y_d     = '0;
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                end
            end
            ST_DIV: begin
                rem_d = rem_chain[UNROLL];
                quo_d = {quo_q[24-UNROLL:0], qbit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(N - 1)) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                y_d     = res_y;
                ovf_d   = res_ovf;
                dbz_d   = res_dbz;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            m2_q    <= '0;
            e1_q    <= '0;
            e2_q    <= '0;
            sign_q  <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            m2_q    <= m2_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            sign_q  <= sign_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_fdiv.sv
// Randomized self-checking bench for fdiv: UNROLL=1 and UNROLL=5 instances checked each cycle against an arithmetic model.
module tb_fdiv;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       in_valid_s = '0;
    logic [1:0]       in_ready_s;
    logic [1:0][31:0] x1_s = '0;
    logic [1:0][31:0] x2_s = '0;
    logic [1:0]       out_valid_s;
    logic [1:0]       out_ready_s = '0;
    logic [1:0][31:0] y_s;
    logic [1:0]       ovf_s;
    logic [1:0]       dbz_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    fdiv #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .x1(x1_s[0]), .x2(x2_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .y(y_s[0]), .ovf(ovf_s[0]), .dbz(dbz_s[0])
    );

    fdiv #(.UNROLL(5)) u_dut5 (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .x1(x1_s[1]), .x2(x2_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .y(y_s[1]), .ovf(ovf_s[1]), .dbz(dbz_s[1])
    );

    typedef struct packed {
        logic        ovf;
        logic        dbz;
        logic [31:0] y;
    } res_t;

    typedef struct {
        res_t        r;
        logic [31:0] a;
        logic [31:0] b;
        int          acc;
        int          lat;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: divide the real mantissas with wide integer arithmetic, then apply the number rules.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        int e1, e2, ye, adj;
        longint unsigned m1, m2, q, frac;
        logic s;
        s  = a[31] ^ b[31];
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        r.ovf = 1'b0;
        r.dbz = 1'b0;
        r.y   = {s, 31'b0};
        if (e2 == 0) begin
            r.dbz = 1'b1;
            r.y   = {s, 8'hFF, 23'b0};
        end else if (e1 == 255) begin
            r.y = {s, 8'hFF, 23'b0};
        end else if (e1 == 0 || e2 == 255) begin
            r.y = {s, 31'b0};
        end else begin
            m1 = 64'(a[22:0]) + 64'd8388608;
            m2 = 64'(b[22:0]) + 64'd8388608;
            q  = (m1 * 64'd16777216) / m2;
            if (q >= 64'd16777216) begin
                frac = (q / 2) % 64'd8388608;
                adj  = 0;
            end else begin
                frac = q % 64'd8388608;
                adj  = -1;
            end
            ye = e1 - e2 + 127 + adj;
            if (ye >= 255) begin
                r.ovf = 1'b1;
                r.y   = {s, 8'hFF, 23'b0};
            end else if (ye > 0) begin
                r.y = {s, 8'(ye), 23'(frac)};
            end
        end
        return r;
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    function automatic int exp_latency(input int n, input logic [31:0] a, input logic [31:0] b);
`ifdef FDIV_EARLY_SPECIAL_EN
        if (is_special(a, b)) return 1;
`else
        if (is_special(a, b) && 1'b0) return 1;
`endif
        return n + 1;
    endfunction

    // One monitor per instance: tracks the outstanding operation and checks handshake, latency and result each cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        localparam int NCYC = (gi == 0) ? 25 : 5;
        exp_t pend[$];
        bit   seen = 1'b0;
        always @(negedge clk) begin
            if (!rstn) begin
                pend.delete();
                seen = 1'b0;
            end else begin
                check($sformatf("in_ready_d%0d", gi), 64'(in_ready_s[gi]), 64'(pend.size() == 0));
                if (pend.size() == 0) begin
                    check($sformatf("out_valid_idle_d%0d", gi), 64'(out_valid_s[gi]), 64'd0);
                end else begin
                    check($sformatf("out_valid_lat_d%0d", gi), 64'(out_valid_s[gi]),
                          64'(seen || (cyc - pend[0].acc >= pend[0].lat)));
                    if (out_valid_s[gi]) begin
                        seen = 1'b1;
                        check($sformatf("result_d%0d", gi),
                              {30'd0, ovf_s[gi], dbz_s[gi], y_s[gi]}, {30'd0, pend[0].r});
                        if (out_ready_s[gi]) begin
                            $display("d%0d op x1=%h x2=%h -> y=%h ovf=%0d dbz=%0d lat=%0d",
                                     gi, pend[0].a, pend[0].b, y_s[gi], ovf_s[gi], dbz_s[gi],
                                     cyc - pend[0].acc);
                            void'(pend.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
                if (in_valid_s[gi] && in_ready_s[gi]) begin
                    exp_t e;
                    e.r   = model(x1_s[gi], x2_s[gi]);
                    e.a   = x1_s[gi];
                    e.b   = x2_s[gi];
                    e.acc = cyc + 1;
                    e.lat = exp_latency(NCYC, x1_s[gi], x2_s[gi]);
                    pend.push_back(e);
                end
            end
        end
    end

    task automatic wait_ready(input int d);
        int t = 0;
        while (!in_ready_s[d] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready_s[d]) begin
            checks++; errors++;
            $display("FAIL timeout_in_ready_d%0d: in_ready=0, expected 1 within 200 cycles", d);
        end
    endtask

    task automatic wait_out(input int d);
        int t = 0;
        while (!out_valid_s[d] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid_s[d]) begin
            checks++; errors++;
            $display("FAIL timeout_out_valid_d%0d: out_valid=0, expected 1 within 200 cycles", d);
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input int stall);
        wait_ready(d);
        in_valid_s[d] = 1'b1;
        x1_s[d] = a;
        x2_s[d] = b;
        @(posedge clk); #1;
        in_valid_s[d] = 1'b0;
        x1_s[d] = $urandom;
        x2_s[d] = $urandom;
        wait_out(d);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready_s[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[d] = 1'b0;
    endtask

    task automatic backpressure(input int d);
        wait_ready(d);
        in_valid_s[d] = 1'b1;
        x1_s[d] = 32'h40C00000;
        x2_s[d] = 32'h40000000;
        @(posedge clk); #1;
        in_valid_s[d] = 1'b0;
        wait_out(d);
        in_valid_s[d] = 1'b1;
        x1_s[d] = 32'h3F800000;
        x2_s[d] = 32'h40400000;
        repeat (5) begin
            @(posedge clk); #1;
            check($sformatf("bp_in_ready_low_d%0d", d), 64'(in_ready_s[d]), 64'd0);
        end
        out_ready_s[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[d] = 1'b0;
        check($sformatf("bp_in_ready_after_d%0d", d), 64'(in_ready_s[d]), 64'd1);
        @(posedge clk); #1;
        in_valid_s[d] = 1'b0;
        wait_out(d);
        out_ready_s[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[d] = 1'b0;
    endtask

    function automatic logic [31:0] rand_fp();
        int k;
        int e;
        logic [31:0] v;
        k = int'($urandom_range(0, 9));
        case (k)
            0:       e = 0;
            1:       e = 255;
            2:       e = int'($urandom_range(1, 12));
            3:       e = int'($urandom_range(243, 254));
            default: e = int'($urandom_range(1, 254));
        endcase
        v = $urandom;
        return {v[31], 8'(e), v[22:0]};
    endfunction

    logic [31:0] dir_a [7] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h7F000000,
                               32'h00800000, 32'h00000000, 32'hFF800000};
    logic [31:0] dir_b [7] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h3E800000,
                               32'h7F000000, 32'h00000000, 32'hC0000000};

    initial begin
        res_t r;
        // Hand-derived values pin the model.
        r = model(32'h40C00000, 32'h40000000);
        check("pin_6_div_2", 64'(r), 64'({1'b0, 1'b0, 32'h40400000}));
        r = model(32'h3F800000, 32'h40400000);
        check("pin_1_div_3", 64'(r), 64'({1'b0, 1'b0, 32'h3EAAAAAA}));
        r = model(32'hBF800000, 32'h00000000);
        check("pin_div_zero", 64'(r), 64'({1'b0, 1'b1, 32'hFF800000}));
        r = model(32'h7F000000, 32'h3E800000);
        check("pin_overflow", 64'(r), 64'({1'b1, 1'b0, 32'h7F800000}));
        r = model(32'h00800000, 32'h7F000000);
        check("pin_underflow", 64'(r), 64'({1'b0, 1'b0, 32'h00000000}));

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_in_ready_d%0d", d), 64'(in_ready_s[d]), 64'd1);
            check($sformatf("rst_out_valid_d%0d", d), 64'(out_valid_s[d]), 64'd0);
            check($sformatf("rst_y_d%0d", d), 64'(y_s[d]), 64'd0);
            check($sformatf("rst_ovf_d%0d", d), 64'(ovf_s[d]), 64'd0);
            check($sformatf("rst_dbz_d%0d", d), 64'(dbz_s[d]), 64'd0);
        end
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 7; i++) begin
                run_op(d, dir_a[i], dir_b[i], i % 3);
            end
            backpressure(d);
        end

        // Reset while the UNROLL=1 instance is at DIV cycle 10.
        wait_ready(0);
        in_valid_s[0] = 1'b1;
        x1_s[0] = 32'h40C00000;
        x2_s[0] = 32'h40000000;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid_s[0]), 64'd0);
        check("async_rst_in_ready", 64'(in_ready_s[0]), 64'd1);
        check("async_rst_y", 64'(y_s[0]), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        run_op(0, 32'h40C00000, 32'h40000000, 0);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                run_op(d, rand_fp(), rand_fp(), int'($urandom_range(0, 3)));
            end
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
